envia_resultado: RTL and testbench
==================================

# envia_resultado

Result transmitter of the arithmetic coprocessor. Holds the 25-element, 8-bit result matrix written by the compute core and returns it to the HPS one element at a time. It uses the same 32-bit PIO word pair and flag/ack handshake the HPS uses to load operands, but with data flowing FPGA→HPS: HPS raises a request, the block presents the element and acks, and HPS drops the request to advance.

## Interface
Parameters:
- N_ELEM, 25, elements per matrix (index 0..N_ELEM-1)
- DATA_W, 8, element width

Ports:
- clk  in  1  clock; HPS PIO and core share this domain; no synchronizers
- reset  in  1  asynchronous, active-high
- res_wr_en  in  1  core write strobe into result storage
- res_wr_addr  in  5  element index 0..24; values ≥ N_ELEM ignored
- res_wr_data  in  8  element value
- res_arm  in  1  one-cycle pulse from core: results complete, start transfer
- hps_in  in  32  [0] req, [1] restart, [31:2] ignored
- hps_out  out  32  [0] ack, [8:1] data, [13:9] index, [14] ready, [15] last, [16] overrun (sticky), [31:17] zero

## Operation
- Storage: 25×8 register array, not reset.
- States: IDLE, READY, PRESENT, DONE.
- IDLE: ready=0, ack=0. Writes accepted. res_arm → READY, index←0.
- READY: ready=1. req=1 → PRESENT; data←mem[index], ack←1. req=0 with restart=1 → index←0, stay READY.
- PRESENT: ack=1, data/index held stable while req=1. req=0 → ack←0. If index==N_ELEM-1, go DONE and index←0. Otherwise index←index+1 and go READY.
- DONE: ready=0, ack=0. Writes accepted. res_arm → READY, index←0. restart=1 with req=0 → READY, index←0 (re-read the same results).
- last = 1 whenever index==N_ELEM-1 in READY or PRESENT.
- Writes in READY or PRESENT are dropped, and overrun←1. overrun clears only on res_arm accepted or reset.
- res_arm in READY or PRESENT is ignored. It does not reset the index.
- Simultaneous res_wr_en and accepted res_arm in the same cycle: the write lands first, then arm takes effect (the element is included).
- restart during PRESENT is ignored.
- req=1 held on entry to READY (for example after an arm): counts as a new request; PRESENT next cycle.

## Timing
- Reset (async): state IDLE, index 0, hps_out = 0 (all bits).
- All hps_out bits are registered.
- req sampled high in READY at edge k: ack=1 and valid data visible after edge k+1. Latency is 1 cycle.
- req sampled low in PRESENT at edge k: ack=0 and index updated after edge k+1. A new request can be served the following edge.
- Minimum full element cycle: 2 clocks (req high one cycle, req low one cycle).
- Full 25-element transfer: ≥50 clocks after arm.
- res_arm → ready=1 after the next edge.
- Reset mid-transfer: immediate return to IDLE, ack drops asynchronously, and storage is kept. HPS must wait for a new res_arm.
- Index wraps 24→0 only via the DONE transition, never by increment overflow.

## Test plan
- Write mem[i]=i+1 for i=0..24, then pulse arm. Run 25 req handshakes. Expect data 1..25 and index 0..24, last=1 only on the 25th, then DONE with ready=0 and index=0.
- req high at edge k in READY: ack=0 at k, ack=1 with data valid after k+1. Hold req for 10 cycles: data/index stable, ack stays 1.
- Write addr 3=0xAA during READY: overrun=1 and mem[3] is unchanged (reads its old value). Next res_arm clears overrun.
- After DONE, set restart=1 with req=0: READY, index=0, and a reread returns identical data. restart during PRESENT: no effect.
- Assert reset during PRESENT at element 7: hps_out=0 immediately. Arm again: transfer restarts at index 0 and mem contents are kept.
- Same cycle res_wr_en (addr 0, 0x55) and res_arm from DONE: the first element read is 0x55.

Source files
------------

// File: rtl/envia_resultado.sv
// ---------------------------------------------------------------------------
// envia_resultado
//
// Result transmitter of the arithmetic coprocessor. The compute core writes
// an N_ELEM x DATA_W result matrix into local storage and then arms the
// block. The HPS reads the matrix back one element per req/ack handshake
// over a 32-bit PIO word pair:
//   - HPS raises req. The block presents mem[index] and raises ack.
//   - HPS drops req. The block drops ack and advances the index.
// After the last element the block parks in DONE. From DONE it can be
// re-armed with new results, or restarted to re-read the same ones.
//
// Ports
//   clk          clock shared by the core and the HPS PIO
//   reset        asynchronous, active-high
//   res_wr_en    core write strobe into result storage
//   res_wr_addr  element index; out-of-range addresses are ignored
//   res_wr_data  element value
//   res_arm      one-cycle pulse: results complete, start a transfer
//   hps_in       [0] req, [1] restart, [31:2] unused
//   hps_out      [0] ack, [8:1] data, [13:9] index, [14] ready,
//                [15] last, [16] overrun (sticky), [31:17] zero
// ---------------------------------------------------------------------------
module envia_resultado #(
    parameter int N_ELEM = 25,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_wr_en,
    input  logic [4:0]        res_wr_addr,
    input  logic [DATA_W-1:0] res_wr_data,
    input  logic              res_arm,
    input  logic [31:0]       hps_in,
    output logic [31:0]       hps_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READY   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [4:0] LAST_IDX = 5'(N_ELEM - 1);

    state_e            state_q, state_d;
    logic [4:0]        index_q, index_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ack_q, ack_d;
    logic              ready_q, ready_d;
    logic              last_q, last_d;
    logic              overrun_q, overrun_d;

    // Result storage is deliberately left out of reset so that a reset
    // mid-transfer keeps the results for a later re-arm.
    logic [DATA_W-1:0] mem_q [N_ELEM];

    logic req_s;
    logic restart_s;
    logic addr_ok_s;
    logic wr_accept_s;
    logic unused_hps_s;

    assign req_s        = hps_in[0];
    assign restart_s    = hps_in[1];
    assign addr_ok_s    = (res_wr_addr <= LAST_IDX);
    assign unused_hps_s = ^hps_in[31:2];

    // Next-state, index, captured data and output-flag computation.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        data_d      = data_q;
        overrun_d   = overrun_q;
        wr_accept_s = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Storage is only writable while no transfer is running.
                // A write in the same cycle as an arm lands before the
                // transfer starts, so that element is read back.
                wr_accept_s = res_wr_en & addr_ok_s;
                if (res_arm) begin
                    state_d   = ST_READY;
                    index_d   = 5'd0;
                    overrun_d = 1'b0;
                end else if ((state_q == ST_DONE) && restart_s && !req_s) begin
                    // Re-read the results already held, without a new arm.
                    state_d = ST_READY;
                    index_d = 5'd0;
                end else begin
                    state_d = state_q;
                end
            end

            ST_READY: begin
                if (res_wr_en) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (req_s) begin
                    state_d = ST_PRESENT;
                    data_d  = mem_q[index_q];
                end else if (restart_s) begin
                    index_d = 5'd0;
                end else begin
                    state_d = ST_READY;
                end
            end

            ST_PRESENT: begin
                if (res_wr_en) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                // restart is ignored here; only the falling req matters.
                if (!req_s) begin
                    if (index_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        index_d = 5'd0;
                    end else begin
                        state_d = ST_READY;
                        index_d = index_q + 5'd1;
                    end
                end else begin
                    state_d = ST_PRESENT;
                end
            end

            default: begin
                state_d = ST_IDLE;
                index_d = 5'd0;
            end
        endcase

        // Flags are computed from the next state so that every hps_out bit
        // comes straight from a flop.
        ack_d   = (state_d == ST_PRESENT);
        ready_d = (state_d == ST_READY);
        last_d  = ((state_d == ST_READY) || (state_d == ST_PRESENT)) &&
                  (index_d == LAST_IDX);
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            index_q   <= 5'd0;
            data_q    <= '0;
            ack_q     <= 1'b0;
            ready_q   <= 1'b0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            ready_q   <= ready_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    // Result storage write port.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_q[res_wr_addr] <= res_wr_data;
        end
    end

    assign hps_out = {15'd0, overrun_q, last_q, ready_q, index_q, data_q, ack_q};

endmodule

// File: tb/tb_envia_resultado.sv
// ---------------------------------------------------------------------------
// Testbench for envia_resultado. A transaction-level model (storage array,
// a "transfer active" flag, a "presenting" flag, a position counter and a
// "results already read" flag) predicts the full hps_out word after every
// clock edge. Each scenario task drives stimulus and compares inline.
// ---------------------------------------------------------------------------
module tb_envia_resultado;

    localparam int N = 25;

    logic        clk;
    logic        reset;
    logic        res_wr_en;
    logic [4:0]  res_wr_addr;
    logic [7:0]  res_wr_data;
    logic        res_arm;
    logic [31:0] hps_in;
    logic [31:0] hps_out;

    int checks = 0;
    int errors = 0;

    envia_resultado #(.N_ELEM(25), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .res_wr_en  (res_wr_en),
        .res_wr_addr(res_wr_addr),
        .res_wr_data(res_wr_data),
        .res_arm    (res_arm),
        .hps_in     (hps_in),
        .hps_out    (hps_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] mem_m [N];
    bit         busy_m;      // transfer in progress (ready or presenting)
    bit         showing_m;   // element currently presented with ack
    bit         finished_m;  // a full pass has completed (restart allowed)
    bit         ovr_m;
    int         pos_m;
    logic [7:0] dat_m;

    function automatic void model_reset();
        busy_m     = 1'b0;
        showing_m  = 1'b0;
        finished_m = 1'b0;
        ovr_m      = 1'b0;
        pos_m      = 0;
        dat_m      = 8'd0;
    endfunction

    function automatic void model_edge();
        bit req;
        bit rst;
        req = hps_in[0];
        rst = hps_in[1];
        if (!busy_m) begin
            if (res_wr_en && (int'(res_wr_addr) < N)) mem_m[res_wr_addr] = res_wr_data;
            if (res_arm) begin
                busy_m = 1'b1; showing_m = 1'b0; pos_m = 0; ovr_m = 1'b0;
            end else if (finished_m && rst && !req) begin
                busy_m = 1'b1; showing_m = 1'b0; pos_m = 0;
            end
        end else begin
            if (res_wr_en) ovr_m = 1'b1;
            if (!showing_m) begin
                if (req) begin
                    showing_m = 1'b1;
                    dat_m     = mem_m[pos_m];
                end else if (rst) begin
                    pos_m = 0;
                end
            end else if (!req) begin
                showing_m = 1'b0;
                if (pos_m == N - 1) begin
                    busy_m = 1'b0; finished_m = 1'b1; pos_m = 0;
                end else begin
                    pos_m = pos_m + 1;
                end
            end
        end
    endfunction

    function automatic logic [31:0] exp_word();
        logic [31:0] w;
        w       = 32'd0;
        w[0]    = showing_m;
        w[8:1]  = dat_m;
        w[13:9] = 5'(pos_m);
        w[14]   = busy_m && !showing_m;
        w[15]   = busy_m && (pos_m == N - 1);
        w[16]   = ovr_m;
        return w;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
    endtask

    task automatic load_mem(input bit seq);
        for (int i = 0; i < N; i++) begin
            res_wr_en   = 1'b1;
            res_wr_addr = 5'(i);
            res_wr_data = seq ? 8'(i + 1) : 8'($urandom_range(0, 255));
            tick();
        end
        res_wr_en = 1'b0;
    endtask

    task automatic arm_pulse();
        res_arm = 1'b1;
        tick();
        res_arm = 1'b0;
    endtask

    // Drives handshakes from the model's view; always ends within 2*N cycles.
    task automatic run_to_done();
        while (busy_m) begin
            hps_in = showing_m ? 32'd0 : 32'd1;
            tick();
        end
        hps_in = 32'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; res_wr_en = 1'b0; res_wr_addr = 5'd0; res_wr_data = 8'd0;
        res_arm = 1'b0; hps_in = 32'd0;
        model_reset();
        tick(); tick();
        checks++;
        if (hps_out !== 32'd0) begin
            errors++; $display("FAIL reset_out got %h exp %h", hps_out, 32'd0);
        end
        reset = 1'b0;
        // req and restart in IDLE must do nothing.
        hps_in = 32'd3;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (hps_out !== exp_word()) begin
                errors++; $display("FAIL idle_ignore got %h exp %h", hps_out, exp_word());
            end
        end
        hps_in = 32'd0;
    endtask

    task automatic test_full_transfer();
        int hi;
        int lo;
        logic [14:0] got_f;
        logic [14:0] exp_f;
        load_mem(1'b1);
        arm_pulse();
        checks++;
        if (hps_out !== 32'h0000_4000) begin
            errors++; $display("FAIL arm_ready got %h exp %h", hps_out, 32'h0000_4000);
        end
        for (int e = 0; e < N; e++) begin
            hps_in = 32'd1;
            hi = $urandom_range(1, 3);
            for (int h = 0; h < hi; h++) begin
                tick();
                checks++;
                if (hps_out !== exp_word()) begin
                    errors++; $display("FAIL xfer_present e=%0d got %h exp %h", e, hps_out, exp_word());
                end
            end
            exp_f = {(e == N - 1), 5'(e), 8'(e + 1), 1'b1};
            got_f = {hps_out[15], hps_out[13:9], hps_out[8:1], hps_out[0]};
            checks++;
            if (got_f !== exp_f) begin
                errors++; $display("FAIL xfer_elem e=%0d got %h exp %h", e, got_f, exp_f);
            end
            hps_in = 32'd0;
            lo = $urandom_range(1, 2);
            for (int l = 0; l < lo; l++) begin
                tick();
                checks++;
                if (hps_out !== exp_word()) begin
                    errors++; $display("FAIL xfer_release e=%0d got %h exp %h", e, hps_out, exp_word());
                end
            end
        end
        checks++;
        if ({hps_out[14], hps_out[13:9], hps_out[0]} !== 7'd0) begin
            errors++; $display("FAIL done_state got %h exp ready=0 index=0 ack=0", hps_out);
        end
    endtask

    task automatic test_hold();
        // req already high when the arm lands: READY first, PRESENT next edge.
        res_arm = 1'b1; hps_in = 32'd1;
        tick();
        res_arm = 1'b0;
        checks++;
        if (hps_out[0] !== 1'b0 || hps_out[14] !== 1'b1) begin
            errors++; $display("FAIL hold_latency got %h exp ack=0 ready=1", hps_out);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (hps_out !== exp_word() || hps_out[8:1] !== mem_m[0] || hps_out[0] !== 1'b1) begin
                errors++; $display("FAIL hold_stable c=%0d got %h exp %h", c, hps_out, exp_word());
            end
        end
        hps_in = 32'd0;
        tick();
        // An arm during a transfer is ignored and keeps the index.
        arm_pulse();
        checks++;
        if (hps_out !== exp_word() || hps_out[13:9] !== 5'd1) begin
            errors++; $display("FAIL arm_in_ready got %h exp %h", hps_out, exp_word());
        end
        run_to_done();
    endtask

    task automatic test_overrun();
        logic [7:0] old3;
        old3 = mem_m[3];
        arm_pulse();
        res_wr_en = 1'b1; res_wr_addr = 5'd3; res_wr_data = 8'hAA;
        tick();
        res_wr_en = 1'b0;
        checks++;
        if (hps_out[16] !== 1'b1 || hps_out !== exp_word()) begin
            errors++; $display("FAIL overrun_set got %h exp %h", hps_out, exp_word());
        end
        for (int e = 0; e < 4; e++) begin
            hps_in = 32'd1; tick();
            hps_in = 32'd0; tick();
        end
        hps_in = 32'd1; tick();   // element 4 presented
        hps_in = 32'd0;
        checks++;
        if (dat_m !== mem_m[4] || hps_out !== exp_word()) begin
            errors++; $display("FAIL overrun_elem4 got %h exp %h", hps_out, exp_word());
        end
        // Re-read element 3 via restart path later; check stored value directly now.
        checks++;
        if (mem_m[3] !== old3 || dut.mem_q[3] !== old3) begin
            errors++; $display("FAIL overrun_keep got %h exp %h", dut.mem_q[3], old3);
        end
        run_to_done();
        arm_pulse();
        checks++;
        if (hps_out[16] !== 1'b0 || hps_out !== exp_word()) begin
            errors++; $display("FAIL overrun_clear got %h exp %h", hps_out, exp_word());
        end
        run_to_done();
    endtask

    task automatic test_restart();
        hps_in = 32'd2;
        tick();
        checks++;
        if (hps_out[14] !== 1'b1 || hps_out[13:9] !== 5'd0 || hps_out !== exp_word()) begin
            errors++; $display("FAIL restart_done got %h exp %h", hps_out, exp_word());
        end
        for (int e = 0; e < 4; e++) begin
            hps_in = 32'd1; tick();
            hps_in = 32'd0; tick();
        end
        hps_in = 32'd1; tick();          // PRESENT at index 4
        hps_in = 32'd3; tick();          // restart while presenting
        checks++;
        if (hps_out[13:9] !== 5'd4 || hps_out[0] !== 1'b1 || hps_out !== exp_word()) begin
            errors++; $display("FAIL restart_present got %h exp %h", hps_out, exp_word());
        end
        hps_in = 32'd2; tick();          // req drops, restart still high
        checks++;
        if (hps_out[13:9] !== 5'd5 || hps_out !== exp_word()) begin
            errors++; $display("FAIL restart_release got %h exp %h", hps_out, exp_word());
        end
        hps_in = 32'd2; tick();          // restart in READY rewinds
        checks++;
        if (hps_out[13:9] !== 5'd0 || hps_out !== exp_word()) begin
            errors++; $display("FAIL restart_ready got %h exp %h", hps_out, exp_word());
        end
        for (int e = 0; e < N; e++) begin
            hps_in = 32'd1; tick();
            checks++;
            if (hps_out[8:1] !== mem_m[e] || hps_out[13:9] !== 5'(e) || hps_out !== exp_word()) begin
                errors++; $display("FAIL reread e=%0d got %h exp %h", e, hps_out, exp_word());
            end
            hps_in = 32'd0; tick();
        end
    endtask

    task automatic test_reset_mid();
        arm_pulse();
        for (int e = 0; e < 7; e++) begin
            hps_in = 32'd1; tick();
            hps_in = 32'd0; tick();
        end
        hps_in = 32'd1; tick();
        checks++;
        if (hps_out[13:9] !== 5'd7 || hps_out[0] !== 1'b1) begin
            errors++; $display("FAIL mid_setup got %h exp index=7 ack=1", hps_out);
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (hps_out !== 32'd0) begin
            errors++; $display("FAIL reset_async got %h exp %h", hps_out, 32'd0);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (hps_out !== exp_word()) begin
            errors++; $display("FAIL reset_idle got %h exp %h", hps_out, exp_word());
        end
        hps_in = 32'd0;
        arm_pulse();
        for (int e = 0; e < N; e++) begin
            hps_in = 32'd1; tick();
            checks++;
            if (hps_out[8:1] !== mem_m[e] || hps_out[13:9] !== 5'(e) || hps_out !== exp_word()) begin
                errors++; $display("FAIL post_reset e=%0d got %h exp %h", e, hps_out, exp_word());
            end
            hps_in = 32'd0; tick();
        end
    endtask

    task automatic test_wr_arm_same();
        res_wr_en = 1'b1; res_wr_addr = 5'd0; res_wr_data = 8'h55; res_arm = 1'b1;
        tick();
        res_wr_en = 1'b0; res_arm = 1'b0;
        hps_in = 32'd1; tick();
        checks++;
        if (hps_out[8:1] !== 8'h55 || hps_out !== exp_word()) begin
            errors++; $display("FAIL wr_arm_same got %h exp data 55", hps_out);
        end
        run_to_done();
    endtask

    task automatic test_random();
        load_mem(1'b0);
        arm_pulse();
        for (int c = 0; c < 600; c++) begin
            res_wr_en   = ($urandom_range(0, 7) == 0);
            res_wr_addr = 5'($urandom_range(0, 31));
            res_wr_data = 8'($urandom_range(0, 255));
            res_arm     = ($urandom_range(0, 19) == 0);
            hps_in      = {30'd0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1)};
            tick();
            checks++;
            if (hps_out !== exp_word()) begin
                errors++; $display("FAIL rand c=%0d got %h exp %h", c, hps_out, exp_word());
            end
        end
        res_wr_en = 1'b0; res_arm = 1'b0; hps_in = 32'd0;
    endtask

    initial begin
        test_reset();
        test_full_transfer();
        test_hold();
        test_overrun();
        test_restart();
        test_reset_mid();
        test_wr_arm_same();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
